// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared op codes, FSM state encoding and HI/LO write-enable codes
//          for the HI/LO multiply/divide sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] HL_WR_NONE = 2'b00;
    localparam logic [1:0] HL_WR_HI   = 2'b10;
    localparam logic [1:0] HL_WR_LO   = 2'b01;
    localparam logic [1:0] HL_WR_BOTH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_CALC  = 3'd2,
        S_FIX   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op <= OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iter_core.sv
// ============================================================================
// Module : mdu_iter_core
// Brief  : One shift-add multiply step or one restoring-divide step on the
//          {acc, lo} register pair.  Pure combinational datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        // Multiply: lo holds the multiplier, consumed LSB first; the carry
        // out of the add is kept and shifted into the top of acc.
        w_sum   = {1'b0, acc_in} + (lo_in[0] ? {1'b0, operand} : '0);
        // Divide: lo holds the dividend, shifted MSB first into the remainder.
        w_shift = {acc_in, lo_in[WIDTH-1]};
        w_fits  = (w_shift >= {1'b0, operand});
        w_diff  = w_shift[WIDTH-1:0] - operand;

        if (is_div) begin
            acc_out = w_fits ? w_diff : w_shift[WIDTH-1:0];
            lo_out  = {lo_in[WIDTH-2:0], w_fits};
        end else begin
            acc_out = w_sum[WIDTH:1];
            lo_out  = {w_sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/hilo_mdu_ctrl.sv
// ============================================================================
// Module : hilo_mdu_ctrl
// Brief  : Multi-cycle MULT/DIV sequencer and sole writer of HI/LO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] dinHi,
    output logic [WIDTH-1:0] dinLo,
    output logic [1:0]       hlWrite
);

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_opnd_a;
    logic [WIDTH-1:0] r_opnd_b;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_is_div;
    logic             r_div_zero;
    logic             r_busy;
    logic [WIDTH-1:0] r_din_hi;
    logic [WIDTH-1:0] r_din_lo;
    logic [1:0]       r_hl_write;

    logic [WIDTH-1:0]   w_din_hi_nxt;
    logic [WIDTH-1:0]   w_din_lo_nxt;
    logic [1:0]         w_hl_write_nxt;
    logic [WIDTH-1:0]   w_acc_step;
    logic [WIDTH-1:0]   w_lo_step;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_iter_core (
        .is_div  (r_is_div),
        .acc_in  (r_acc),
        .lo_in   (r_opnd_a),
        .operand (r_opnd_b),
        .acc_out (w_acc_step),
        .lo_out  (w_lo_step)
    );

    // Sign correction of the magnitude result.  A zero divisor leaves the
    // all-ones quotient unsigned so DIV and DIVU agree on LO.
    always_comb begin
        w_prod_mag = {r_acc, r_opnd_a};
        w_prod     = (r_sign_a ^ r_sign_b) ? -w_prod_mag : w_prod_mag;
        if (r_is_div) begin
            w_fix_hi = r_sign_a ? -r_acc : r_acc;
            w_fix_lo = ((r_sign_a ^ r_sign_b) && !r_div_zero) ? -r_opnd_a : r_opnd_a;
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hl_write_nxt = HL_WR_NONE;
        w_din_hi_nxt   = r_din_hi;
        w_din_lo_nxt   = r_din_lo;
        case (r_state)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (op_is_arith(op)) begin
                        w_state_nxt = S_PREP;
                    end else if (op == OP_MTHI) begin
                        w_state_nxt    = S_WRITE;
                        w_din_hi_nxt   = srcA;
                        w_hl_write_nxt = HL_WR_HI;
                    end else if (op == OP_MTLO) begin
                        w_state_nxt    = S_WRITE;
                        w_din_lo_nxt   = srcA;
                        w_hl_write_nxt = HL_WR_LO;
                    end
                end
            end
            S_PREP: begin
                w_state_nxt = cancel ? S_IDLE : S_CALC;
            end
            S_CALC: begin
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == C_LAST_STEP) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt    = S_WRITE;
                    w_din_hi_nxt   = w_fix_hi;
                    w_din_lo_nxt   = w_fix_lo;
                    w_hl_write_nxt = HL_WR_BOTH;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd_a   <= '0;
            r_opnd_b   <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_din_hi   <= '0;
            r_din_lo   <= '0;
            r_hl_write <= HL_WR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_din_hi   <= w_din_hi_nxt;
            r_din_lo   <= w_din_lo_nxt;
            r_hl_write <= w_hl_write_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_PREP) begin
                        r_opnd_a   <= srcA;
                        r_opnd_b   <= srcB;
                        r_sign_a   <= srcA[WIDTH-1] & op_is_signed(op);
                        r_sign_b   <= srcB[WIDTH-1] & op_is_signed(op);
                        r_is_div   <= op_is_div(op);
                        r_div_zero <= (srcB == '0);
                    end
                end
                S_PREP: begin
                    r_opnd_a <= r_sign_a ? -r_opnd_a : r_opnd_a;
                    r_opnd_b <= r_sign_b ? -r_opnd_b : r_opnd_b;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                S_CALC: begin
                    r_acc    <= w_acc_step;
                    r_opnd_a <= w_lo_step;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign dinHi   = r_din_hi;
    assign dinLo   = r_din_lo;
    assign hlWrite = r_hl_write;

endmodule

`default_nettype wire

// File: tb/tb_hilo_mdu_ctrl.sv
// ============================================================================
// Module : tb_hilo_mdu_ctrl
// Brief  : Self-checking bench for hilo_mdu_ctrl against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        cancel;
    logic        busy;
    logic [31:0] dinHi;
    logic [31:0] dinLo;
    logic [1:0]  hlWrite;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    hilo_mdu_ctrl #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .cancel  (cancel),
        .busy    (busy),
        .dinHi   (dinHi),
        .dinLo   (dinLo),
        .hlWrite (hlWrite)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one op: write mask and the HI/LO values after it.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [1:0] wr, output logic [31:0] hi, output logic [31:0] lo);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        wr = 2'b00;
        hi = m_hi;
        lo = m_lo;
        case (o)
            3'd0: begin
                p  = longint'(sa) * longint'(sb);
                {hi, lo} = p;
                wr = 2'b11;
            end
            3'd1: begin
                pu = {32'b0, a} * {32'b0, b};
                {hi, lo} = pu;
                wr = 2'b11;
            end
            3'd2, 3'd3: begin
                wr = 2'b11;
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (o == 3'd3) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            3'd4: begin
                hi = a;
                wr = 2'b10;
            end
            3'd5: begin
                lo = a;
                wr = 2'b01;
            end
            default: wr = 2'b00;
        endcase
    endtask

    // Issue one op; optionally cancel or re-pulse start in a given busy cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at, input int poke_at);
        logic [1:0]  wr;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          bad;
        model(o, a, b, wr, hi, lo);
        lat   = (o <= 3'd3) ? 35 : 1;
        bad   = 0;
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        tick();
        start = 1'b0;
        srcA  = $urandom;
        srcB  = $urandom;
        if (wr == 2'b00) begin
            chk("nop_busy", busy, 0);
            chk("nop_wr", hlWrite, 0);
            return;
        end
        for (int c = 1; c <= lat; c++) begin
            if (c == lat) begin
                chk("wr_pulse", hlWrite, wr);
                chk("wr_hi", dinHi, hi);
                chk("wr_lo", dinLo, lo);
                chk("wr_busy", busy, 1);
            end else if (busy !== 1'b1 || hlWrite !== 2'b00) begin
                bad++;
            end
            if (c == poke_at) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 5));
                srcA  = $urandom;
                srcB  = $urandom;
            end
            cancel = (c == cancel_at);
            tick();
            start  = 1'b0;
            cancel = 1'b0;
            if (c == cancel_at && c < lat) begin
                chk("cancel_busy", busy, 0);
                chk("cancel_hi", dinHi, m_hi);
                chk("cancel_lo", dinLo, m_lo);
                for (int k = 0; k < lat; k++) begin
                    if (hlWrite !== 2'b00 || busy !== 1'b0) bad++;
                    tick();
                end
                chk("cancel_nowr", bad, 0);
                return;
            end
        end
        chk("busy_hold", bad, 0);
        chk("done_busy", busy, 0);
        chk("done_wr", hlWrite, 0);
        chk("hold_hi", dinHi, hi);
        chk("hold_lo", dinLo, lo);
        m_hi = hi;
        m_lo = lo;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'd0;
        srcA   = '0;
        srcB   = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_wr", hlWrite, 0);
        chk("rst_hi", dinHi, 0);
        chk("rst_lo", dinLo, 0);
        rst = 1'b0;
        tick();

        do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
        do_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        do_op(3'd3, 32'h0000_0007, 32'h0000_0000, 0, 0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 0, 0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd4, 32'h1111_1111, 32'h0, 0, 0);
        do_op(3'd5, 32'h4444_4444, 32'h0, 0, 0);

        // Cancel mid-CALC, then a normal op; cancel in WRITE still writes.
        do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10, 0);
        do_op(3'd0, 32'h0000_1234, 32'hFFFF_0001, 0, 0);
        do_op(3'd3, 32'hDEAD_BEEF, 32'h0000_0100, 35, 0);
        do_op(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 5);
        do_op(3'd6, 32'h1, 32'h1, 0, 0);
        do_op(3'd7, 32'h1, 32'h1, 0, 0);

        // Cancel in IDLE blocks a simultaneous start.
        start  = 1'b1;
        cancel = 1'b1;
        op     = 3'd4;
        srcA   = 32'hDEAD_BEEF;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        chk("idle_cancel_busy", busy, 0);
        chk("idle_cancel_wr", hlWrite, 0);
        tick();
        chk("idle_cancel_hi", dinHi, m_hi);

        // Reset during CALC.
        start = 1'b1;
        op    = 3'd0;
        srcA  = 32'h0001_2345;
        srcB  = 32'h0000_0100;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            start = (c == 5);
            op    = 3'd1;
            srcA  = 32'hCAFE_0000;
            tick();
        end
        start = 1'b0;
        rst   = 1'b1;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_wr", hlWrite, 0);
        chk("mrst_hi", dinHi, 0);
        chk("mrst_lo", dinLo, 0);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        tick();

        for (int i = 0; i < 24; i++) begin
            do_op(3'($urandom_range(0, 5)), pick(), pick(),
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 35)) : 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
